// File: rtl/tour_pkg.sv
// Shared types and constants for the knight's-tour command replayer.
// Headings, opcodes, move bit positions and the replay FSM states.
package tour_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VERT,
    HOLDV,
    HORZ,
    HOLDH
  } state_t;

  localparam logic [7:0] HEAD_N = 8'h00;
  localparam logic [7:0] HEAD_W = 8'h3F;
  localparam logic [7:0] HEAD_S = 8'h7F;
  localparam logic [7:0] HEAD_E = 8'hBF;

  localparam logic [3:0] OP_MOVE         = 4'b0010;
  localparam logic [3:0] OP_MOVE_FANFARE = 4'b0011;

  // Bit positions of the one-hot move, named (dx,dy)
  localparam int MV_M1P2 = 0;
  localparam int MV_P1P2 = 1;
  localparam int MV_M2P1 = 2;
  localparam int MV_M2M1 = 3;
  localparam int MV_M1M2 = 4;
  localparam int MV_P1M2 = 5;
  localparam int MV_P2M1 = 6;
  localparam int MV_P2P1 = 7;

  localparam logic [4:0] LAST_MV   = 5'd23;
  localparam logic [7:0] RESP_IDLE = 8'hA5;
  localparam logic [7:0] RESP_BUSY = 8'h5A;

endpackage

// File: rtl/tour_cmd_if.sv
// Command path between UART wrapper, tour replayer and command processor.
// master = tour_cmd side, slave = the surrounding UART/cmd-processor side.
interface tour_cmd_if;
  import tour_pkg::*;

  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;

  modport master (
    input  cmd_UART,
    input  cmd_rdy_UART,
    output clr_cmd_rdy_UART,
    output cmd,
    output cmd_rdy,
    input  clr_cmd_rdy,
    input  send_resp,
    output resp
  );

  modport slave (
    output cmd_UART,
    output cmd_rdy_UART,
    input  clr_cmd_rdy_UART,
    input  cmd,
    input  cmd_rdy,
    output clr_cmd_rdy,
    output send_resp,
    input  resp
  );

endinterface

// File: rtl/tour_move_decode.sv
// Splits a solver move into vertical and horizontal (heading, squares).
// Prioritised so that non-one-hot values still decode deterministically.
module tour_move_decode
  import tour_pkg::*;
(
  input  logic [7:0] move,
  output logic [7:0] v_head,
  output logic [3:0] v_sq,
  output logic [7:0] h_head,
  output logic [3:0] h_sq
);

  always_comb begin
    v_head = HEAD_S;
    v_sq   = 4'd2;
    priority case (1'b1)
      move[MV_M1P2] | move[MV_P1P2]: begin
        v_head = HEAD_N;
        v_sq   = 4'd2;
      end
      move[MV_M2P1] | move[MV_P2P1]: begin
        v_head = HEAD_N;
        v_sq   = 4'd1;
      end
      move[MV_M2M1] | move[MV_P2M1]: begin
        v_head = HEAD_S;
        v_sq   = 4'd1;
      end
      default: begin
        v_head = HEAD_S;
        v_sq   = 4'd2;
      end
    endcase
  end

  always_comb begin
    h_head = HEAD_W;
    h_sq   = 4'd2;
    priority case (1'b1)
      move[MV_P2M1] | move[MV_P2P1]: begin
        h_head = HEAD_E;
        h_sq   = 4'd2;
      end
      move[MV_P1P2] | move[MV_P1M2]: begin
        h_head = HEAD_E;
        h_sq   = 4'd1;
      end
      move[MV_M1P2] | move[MV_M1M2]: begin
        h_head = HEAD_W;
        h_sq   = 4'd1;
      end
      default: begin
        h_head = HEAD_W;
        h_sq   = 4'd2;
      end
    endcase
  end

endmodule

// File: rtl/tour_cmd.sv
// Muxes UART commands to the command processor, or replays a solved
// knight's tour as a vertical then a horizontal move per solver step.
module tour_cmd
  import tour_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_tour,
  input  logic [7:0] move,
  output logic [4:0] mv_indx,
  tour_cmd_if.master bus
);

  state_t     state_q;
  logic [4:0] mv_indx_q;
  logic [7:0] v_head, h_head;
  logic [3:0] v_sq, h_sq;

  tour_move_decode u_dec (
    .move   (move),
    .v_head (v_head),
    .v_sq   (v_sq),
    .h_head (h_head),
    .h_sq   (h_sq)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mv_indx_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (start_tour) begin
          mv_indx_q <= '0;
          state_q   <= VERT;
        end
        VERT:  if (bus.clr_cmd_rdy) state_q <= HOLDV;
        HOLDV: if (bus.send_resp)   state_q <= HORZ;
        HORZ:  if (bus.clr_cmd_rdy) state_q <= HOLDH;
        HOLDH: if (bus.send_resp) begin
          if (mv_indx_q == LAST_MV) begin
            state_q <= IDLE;
          end else begin
            mv_indx_q <= mv_indx_q + 5'd1;
            state_q   <= VERT;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mv_indx = mv_indx_q;

  always_comb begin
    bus.cmd              = {OP_MOVE, v_head, v_sq};
    bus.cmd_rdy          = 1'b0;
    bus.clr_cmd_rdy_UART = 1'b0;
    bus.resp             = RESP_BUSY;
    unique case (state_q)
      IDLE: begin
        bus.cmd              = bus.cmd_UART;
        bus.cmd_rdy          = bus.cmd_rdy_UART;
        bus.clr_cmd_rdy_UART = bus.clr_cmd_rdy;
        bus.resp             = RESP_IDLE;
      end
      VERT: bus.cmd_rdy = 1'b1;
      HOLDV: ;
      HORZ: begin
        bus.cmd     = {OP_MOVE_FANFARE, h_head, h_sq};
        bus.cmd_rdy = 1'b1;
      end
      HOLDH: begin
        bus.cmd = {OP_MOVE_FANFARE, h_head, h_sq};
        // Last step hands control back to the UART in this same cycle
        if (bus.send_resp && mv_indx_q == LAST_MV)
          bus.resp = RESP_IDLE;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tour_cmd.sv
// Directed bench for tour_cmd: UART pass-through, full replay,
// ignored restart, clr/send overlap and mid-tour reset.
module tb_tour_cmd;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_tour;
  logic [7:0] move;
  logic [4:0] mv_indx;
  logic [7:0] moves [24];

  int n_assert = 0;
  int n_fail   = 0;
  int n_cmds   = 0;

  tour_cmd_if bus ();

  tour_cmd dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_tour (start_tour),
    .move       (move),
    .mv_indx    (mv_indx),
    .bus        (bus.master)
  );

  always #5 clk = ~clk;

  assign move = moves[mv_indx];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Hand-computed commands for each move pattern used below
  function automatic logic [15:0] exp_cmd(input logic [7:0] m,
                                          input bit h);
    logic [15:0] r;
    case (m)
      8'h01:   r = h ? 16'h33F1 : 16'h2002;
      8'h02:   r = h ? 16'h3BF1 : 16'h2002;
      8'h04:   r = h ? 16'h33F2 : 16'h2001;
      8'h08:   r = h ? 16'h33F2 : 16'h27F1;
      8'h10:   r = h ? 16'h33F1 : 16'h27F2;
      8'h20:   r = h ? 16'h3BF1 : 16'h27F2;
      8'h40:   r = h ? 16'h3BF2 : 16'h27F1;
      8'h80:   r = h ? 16'h3BF2 : 16'h2001;
      8'hC3:   r = h ? 16'h3BF2 : 16'h2002;
      default: r = h ? 16'h33F2 : 16'h27F2;
    endcase
    return r;
  endfunction

  // Respond to one tour command: wait, check, latch, finish
  task automatic serve(input int i, input bit h);
    string t;
    int k;
    t = $sformatf("%s%0d", h ? "H" : "V", i);
    k = 0;
    while (bus.cmd_rdy !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk({t, "_rdy"}, {15'd0, bus.cmd_rdy}, 16'd1);
    chk({t, "_cmd"}, bus.cmd, exp_cmd(moves[i], h));
    chk({t, "_idx"}, {11'd0, mv_indx}, i[15:0]);
    n_cmds++;
    if (i == 3 && !h) bus.send_resp = 1'b1;
    bus.clr_cmd_rdy = 1'b1;
    tick();
    bus.clr_cmd_rdy = 1'b0;
    bus.send_resp   = 1'b0;
    chk({t, "_hold"}, {15'd0, bus.cmd_rdy}, 16'd0);
    if (i == 5 && !h) begin
      start_tour = 1'b1;
      tick();
      start_tour = 1'b0;
      chk({t, "_restart_idx"}, {11'd0, mv_indx}, 16'd5);
    end
    tick();
    chk({t, "_stillhold"}, {15'd0, bus.cmd_rdy}, 16'd0);
    bus.send_resp = 1'b1;
    #1;
    chk({t, "_resp"}, {8'd0, bus.resp},
        (h && i == 23) ? 16'h00A5 : 16'h005A);
    tick();
    bus.send_resp = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 24; i++) moves[i] = 8'h01 << (i % 8);
    moves[0]  = 8'h02;
    moves[1]  = 8'h08;
    moves[22] = 8'hC3;
    moves[23] = 8'h00;

    rst_n            = 1'b1;
    start_tour       = 1'b0;
    bus.cmd_UART     = 16'h0000;
    bus.cmd_rdy_UART = 1'b0;
    bus.clr_cmd_rdy  = 1'b0;
    bus.send_resp    = 1'b0;
    #3 rst_n = 1'b0;
    #2;
    chk("rst_rdy",  {15'd0, bus.cmd_rdy}, 16'd0);
    chk("rst_resp", {8'd0, bus.resp}, 16'h00A5);
    chk("rst_idx",  {11'd0, mv_indx}, 16'd0);
    #3 rst_n = 1'b1;
    tick();

    bus.cmd_UART     = 16'h2BF1;
    bus.cmd_rdy_UART = 1'b1;
    #1;
    chk("uart_cmd", bus.cmd, 16'h2BF1);
    chk("uart_rdy", {15'd0, bus.cmd_rdy}, 16'd1);
    bus.clr_cmd_rdy = 1'b1;
    #1;
    chk("uart_clr", {15'd0, bus.clr_cmd_rdy_UART}, 16'd1);
    bus.clr_cmd_rdy = 1'b0;
    tick();

    // UART stays asserted: must be ignored during the tour
    bus.cmd_UART = 16'h1234;
    start_tour   = 1'b1;
    tick();
    start_tour = 1'b0;
    bus.clr_cmd_rdy = 1'b1;
    #1;
    chk("tour_uart_clr", {15'd0, bus.clr_cmd_rdy_UART}, 16'd0);
    bus.clr_cmd_rdy = 1'b0;
    n_cmds = 0;
    for (int i = 0; i < 24; i++) begin
      serve(i, 1'b0);
      serve(i, 1'b1);
    end
    chk("n_cmds", n_cmds[15:0], 16'd48);
    chk("end_resp", {8'd0, bus.resp}, 16'h00A5);
    chk("end_cmd", bus.cmd, 16'h1234);
    bus.cmd_rdy_UART = 1'b0;
    #1;
    chk("end_rdy", {15'd0, bus.cmd_rdy}, 16'd0);

    start_tour = 1'b1;
    tick();
    start_tour = 1'b0;
    chk("t2_idx", {11'd0, mv_indx}, 16'd0);
    for (int i = 0; i < 10; i++) begin
      serve(i, 1'b0);
      serve(i, 1'b1);
    end
    serve(10, 1'b0);
    chk("horz10_rdy", {15'd0, bus.cmd_rdy}, 16'd1);
    chk("horz10_cmd", bus.cmd, exp_cmd(moves[10], 1'b1));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rdy",  {15'd0, bus.cmd_rdy}, 16'd0);
    chk("mid_rst_idx",  {11'd0, mv_indx}, 16'd0);
    chk("mid_rst_resp", {8'd0, bus.resp}, 16'h00A5);
    #3 rst_n = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    chk("post_rst_rdy", {15'd0, bus.cmd_rdy}, 16'd0);
    bus.cmd_UART     = 16'h2BF1;
    bus.cmd_rdy_UART = 1'b1;
    #1;
    chk("post_rst_cmd", bus.cmd, 16'h2BF1);
    chk("post_rst_urdy", {15'd0, bus.cmd_rdy}, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
